// File: rtl/port_word_collector.sv
// port_word_collector
//
// Sits after the serial frame receiver controller. It packs the accepted serial
// bits MSB-first into WORD_W-bit words. Each completed word is written into the
// output register of the port latched at frame start, with a one-clk valid pulse
// on that port. When a frame closes, the block reports the number of complete
// words and flags a trailing partial word.
//
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   clk_en        bit-rate enable; nothing advances while low
//   ser_bit       serial data bit, used when ser_valid=1
//   ser_valid     one data bit per clk_en cycle while high
//   port_sel      destination port, latched with the first bit of a frame
//   frame_done    frame close strobe (coincides with the last data bit, if any)
//   data_out      port p word at [p*WORD_W +: WORD_W], held until overwritten
//   word_valid    one-clk pulse on bit p when port p's word updates
//   frame_end     one-clk pulse when a frame closes
//   frame_words   complete words in the frame just closed, saturating at 255
//   frame_err     one-clk pulse with frame_end if the frame ended mid-word
//   busy          high while a frame is being received
module port_word_collector #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned NPORTS = 4,
  localparam int unsigned PORT_W = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     ser_bit,
  input  logic                     ser_valid,
  input  logic [PORT_W-1:0]        port_sel,
  input  logic                     frame_done,
  output logic [NPORTS*WORD_W-1:0] data_out,
  output logic [NPORTS-1:0]        word_valid,
  output logic                     frame_end,
  output logic [7:0]               frame_words,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e                    state_q, state_d;
  logic [WORD_W-1:0]         shreg_q, shreg_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]                word_cnt_q, word_cnt_d;
  logic [PORT_W-1:0]         port_q, port_d;
  logic [NPORTS*WORD_W-1:0]  data_q, data_d;
  logic [NPORTS-1:0]         word_valid_q, word_valid_d;
  logic                      frame_end_q, frame_end_d;
  logic                      frame_err_q, frame_err_d;
  logic [7:0]                frame_words_q, frame_words_d;

  logic              accept;
  logic              close;
  logic [PORT_W-1:0] port_cur;
  logic [WORD_W-1:0] shift_word;
  logic [CNT_W-1:0]  cnt_inc;

  assign accept     = clk_en & ser_valid;
  assign close      = clk_en & frame_done;
  // The first bit of a frame is steered by the live port_sel, later bits by port_q.
  assign port_cur   = (state_q == StIdle) ? port_sel : port_q;
  assign shift_word = {shreg_q[WORD_W-2:0], ser_bit};
  assign cnt_inc    = bit_cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a bit that arrives together with frame_done in IDLE
  // opens and closes a frame on the same edge, so the FSM stays in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && !close) state_d = StRecv;
      StRecv: if (close)            state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == StRecv);
    data_out    = data_q;
    word_valid  = word_valid_q;
    frame_end   = frame_end_q;
    frame_err   = frame_err_q;
    frame_words = frame_words_q;
  end

  // Datapath next-state: process the accepted bit first, then apply frame close.
  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    port_d        = port_q;
    data_d        = data_q;
    frame_words_d = frame_words_q;
    word_valid_d  = '0;
    frame_end_d   = 1'b0;
    frame_err_d   = 1'b0;

    if (accept) begin
      port_d  = port_cur;
      shreg_d = shift_word;
      if (cnt_inc == CNT_W'(WORD_W)) begin
        data_d[int'(port_cur)*WORD_W +: WORD_W] = shift_word;
        word_valid_d[port_cur] = 1'b1;
        bit_cnt_d  = '0;
        word_cnt_d = (word_cnt_q != 8'hFF) ? word_cnt_q + 8'd1 : word_cnt_q;
      end else begin
        bit_cnt_d = cnt_inc;
      end
    end

    if (close) begin
      frame_end_d   = 1'b1;
      frame_words_d = word_cnt_d;
      frame_err_d   = (bit_cnt_d != '0);
      bit_cnt_d     = '0;
      word_cnt_d    = '0;
      shreg_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      port_q        <= '0;
      data_q        <= '0;
      word_valid_q  <= '0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_words_q <= '0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      port_q        <= port_d;
      data_q        <= data_d;
      word_valid_q  <= word_valid_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
      frame_words_q <= frame_words_d;
    end
  end

endmodule

// File: tb/tb_port_word_collector.sv
// Testbench for port_word_collector (WORD_W=8, NPORTS=4).
// Stimulus pushes hand-computed expected words/frames into queues; an
// independent monitor pops and compares them whenever the DUT pulses.
module tb_port_word_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        ser_bit;
  logic        ser_valid;
  logic [1:0]  port_sel;
  logic        frame_done;
  logic [31:0] data_out;
  logic [3:0]  word_valid;
  logic        frame_end;
  logic [7:0]  frame_words;
  logic        frame_err;
  logic        busy;

  port_word_collector #(
    .WORD_W(8),
    .NPORTS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .port_sel   (port_sel),
    .frame_done (frame_done),
    .data_out   (data_out),
    .word_valid (word_valid),
    .frame_end  (frame_end),
    .frame_words(frame_words),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] word;
  } wexp_t;

  typedef struct {
    int words;
    bit err;
  } fexp_t;

  wexp_t       wq[$];
  fexp_t       fq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wv_count = 0;
  logic [31:0] model_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    wexp_t we;
    fexp_t fe;
    model_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_data = '0;
      end else begin
        if (word_valid != 4'b0) begin
          wv_count++;
          if (wq.size() == 0) begin
            chk("unexpected word_valid", 32'(word_valid), 32'd0);
          end else begin
            we = wq.pop_front();
            chk("word_valid port", 32'(word_valid), 32'd1 << we.port);
            model_data[we.port*8 +: 8] = we.word;
          end
        end
        chk("data_out", data_out, model_data);
        if (frame_end) begin
          if (fq.size() == 0) begin
            chk("unexpected frame_end", 32'(frame_end), 32'd0);
          end else begin
            fe = fq.pop_front();
            chk("frame_words", 32'(frame_words), 32'(fe.words));
            chk("frame_err", 32'(frame_err), 32'(fe.err));
          end
        end else if (frame_err) begin
          chk("frame_err without frame_end", 32'(frame_err), 32'd0);
        end
      end
    end
  end

  task automatic tick(input logic en, input logic v, input logic b, input logic d);
    clk_en     = en;
    ser_valid  = v;
    ser_bit    = b;
    frame_done = d;
    @(posedge clk);
    #1;
  endtask

  // Hold the bit for div clks; only the last one carries clk_en.
  task automatic send_bit(input logic b, input logic v, input logic d, input int div);
    repeat (div - 1) tick(1'b0, v, b, d);
    tick(1'b1, v, b, d);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit last_done,
                           input int div);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(val[i], 1'b1, last_done && (i == 0), div);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] w8;
    rst        = 1'b1;
    clk_en     = 1'b0;
    ser_bit    = 1'b0;
    ser_valid  = 1'b0;
    frame_done = 1'b0;
    port_sel   = 2'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("reset data_out", data_out, 32'd0);
    chk("reset word_valid", 32'(word_valid), 32'd0);
    chk("reset frame_end", 32'(frame_end), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset frame_words", 32'(frame_words), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(2);

    // 0xA5, 0x3C to port 2, clk_en every 4th clk
    port_sel = 2'd2;
    wq.push_back('{port: 2, word: 8'hA5});
    wq.push_back('{port: 2, word: 8'h3C});
    fq.push_back('{words: 2, err: 1'b0});
    send_bit(1'b1, 1'b1, 1'b0, 4);
    chk("busy after first bit", 32'(busy), 32'd1);
    send_bits(32'h25, 7, 1'b0, 4);
    send_bits(32'h3C, 8, 1'b1, 4);
    chk("busy after frame_done", 32'(busy), 32'd0);
    idle(3);

    // 11 bits to port 1: 0xFF then partial 101
    port_sel = 2'd1;
    wq.push_back('{port: 1, word: 8'hFF});
    fq.push_back('{words: 1, err: 1'b1});
    send_bits(32'h7FD, 11, 1'b1, 2);
    idle(3);

    // port_sel switches 0 -> 3 after the first bit; word stays on port 0
    port_sel = 2'd0;
    wq.push_back('{port: 0, word: 8'h5A});
    fq.push_back('{words: 1, err: 1'b0});
    send_bit(1'b0, 1'b1, 1'b0, 2);
    port_sel = 2'd3;
    send_bits(32'h5A, 7, 1'b1, 2);
    idle(3);

    // 0xC3 to port 3 with a 5 clk_en-cycle ser_valid gap mid-word
    port_sel = 2'd3;
    wq.push_back('{port: 3, word: 8'hC3});
    fq.push_back('{words: 1, err: 1'b0});
    send_bits(32'hC, 4, 1'b0, 2);
    repeat (5) send_bit(1'b1, 1'b0, 1'b0, 2);
    chk("busy during gap", 32'(busy), 32'd1);
    send_bits(32'h3, 4, 1'b1, 2);
    idle(3);

    // zero-length frame in IDLE
    fq.push_back('{words: 0, err: 1'b0});
    send_bit(1'b0, 1'b0, 1'b1, 1);
    chk("busy after empty frame", 32'(busy), 32'd0);
    idle(3);

    // reset after 5 bits, then a clean 0x81 frame to port 0
    port_sel = 2'd0;
    send_bits(32'h1F, 5, 1'b0, 1);
    chk("busy before mid-frame reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("async reset data_out", data_out, 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset word_valid", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    wq.push_back('{port: 0, word: 8'h81});
    fq.push_back('{words: 1, err: 1'b0});
    send_bits(32'h81, 8, 1'b1, 3);
    idle(3);

    // 300 words to port 1, clk_en always high; frame_words saturates at 255
    port_sel = 2'd1;
    for (int w = 0; w < 300; w++) begin
      w8 = w[7:0];
      wq.push_back('{port: 1, word: w8});
    end
    fq.push_back('{words: 255, err: 1'b0});
    for (int w = 0; w < 300; w++) begin
      send_bits(32'(w), 8, w == 299, 1);
    end
    // back-to-back frame: first bit on the very next clk_en cycle
    port_sel = 2'd2;
    wq.push_back('{port: 2, word: 8'h0F});
    fq.push_back('{words: 1, err: 1'b0});
    send_bits(32'h0F, 8, 1'b1, 1);
    chk("busy after back-to-back frame", 32'(busy), 32'd0);
    idle(4);

    chk("words still expected", 32'(wq.size()), 32'd0);
    chk("frames still expected", 32'(fq.size()), 32'd0);
    chk("word_valid pulse count", 32'(wv_count), 32'd307);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/port_word_collector.md
# port_word_collector

Downstream stage of the serial frame receiver controller. It consumes the serial data stream that the controller marks valid (`SerOutValid`), together with the captured port number and the `done` strobe. It packs the incoming bits MSB-first into words and writes each completed word into the output register of the addressed port, raising a one-cycle valid pulse on that port. It also reports per-frame word count and framing errors, so the port-side logic never handles raw serial bits.

## Interface
- `WORD_W`, 8, bits per output word (2..16)
- `NPORTS`, 4, number of output ports; `port_sel` width is `$clog2(NPORTS)`
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `clk_en`  in  1  bit-rate enable; same enable the receiver controller uses
- `ser_bit`  in  1  serial data bit, meaningful when `ser_valid=1`
- `ser_valid`  in  1  controller's `SerOutValid`; one data bit per clk_en cycle while high
- `port_sel`  in  $clog2(NPORTS)  port number from the controller's port shift register
- `frame_done`  in  1  controller's `done`; coincides with the last data bit
- `data_out`  out  NPORTS*WORD_W  port p word at bits [p*WORD_W +: WORD_W]
- `word_valid`  out  NPORTS  one-clk pulse on bit p when port p's word updates
- `frame_end`  out  1  one-clk pulse when a frame closes
- `frame_words`  out  8  complete words in the frame just closed, saturating at 255
- `frame_err`  out  1  one-clk pulse with `frame_end` if the frame ended on a partial word
- `busy`  out  1  high in RECV

## Operation
- A bit is accepted at a rising clk edge where `clk_en & ser_valid`. Nothing advances when `clk_en=0`.
- FSM states:
  - IDLE: `bit_cnt=0`, `word_cnt=0`.
  - RECV: collecting bits.
- Transitions:
  - IDLE -> RECV on the first accepted bit. That bit is shifted in, and `port_sel` is latched into `port_q` on the same edge.
  - RECV -> IDLE on `clk_en & frame_done`.
  - `frame_done` seen in IDLE (zero-length frame): produce the `frame_end` pulse with `frame_words=0`, `frame_err=0`, and stay in IDLE.
- Shift register: `shreg <= {shreg[WORD_W-2:0], ser_bit}`, so the first bit received ends up as the word MSB. `bit_cnt` counts 0..WORD_W-1.
- When an accepted bit makes `bit_cnt` reach WORD_W:
  - write the assembled word into the `data_out` slice for `port_q`;
  - pulse `word_valid[port_q]`;
  - reset `bit_cnt` to 0;
  - increment `word_cnt`, saturating at 255.
- Frame close, when `frame_done` arrives with an accepted bit:
  - Process the bit first, including any word completion, then close the frame.
  - `frame_words <=` final `word_cnt`, pulse `frame_end`.
  - If the post-bit `bit_cnt != 0`, pulse `frame_err`. The partial bits are discarded and no `data_out` write occurs.
  - Clear `bit_cnt`, `word_cnt` and `shreg`.
- `frame_done` without `ser_valid` still closes the frame, using the current `bit_cnt` for the error check.
- `ser_valid` low in RECV without `frame_done`: hold all state (gap tolerated).
- `port_sel` changes after latching are ignored until the next frame.
- `data_out` slices hold their last word indefinitely. Non-addressed slices never change.

## Timing
- Reset values: all outputs 0, including `data_out`, `word_valid`, `frame_end`, `frame_err`, `frame_words` and `busy`. FSM in IDLE, `port_q=0`.
- Reset asserted mid-frame: state clears immediately (asynchronous). Partial data is lost, no pulses are emitted, and the next frame starts clean.
- Latency: `data_out` and `word_valid` update on the same edge that accepts the final bit of a word.
- `frame_end`, `frame_err` and `frame_words` update on the edge that accepts `frame_done`.
- All pulses last exactly one clk cycle, even if `clk_en` stays low afterwards.
- `busy` rises on the edge accepting the first bit and falls on the frame_done edge.
- Back-to-back frames: a new first bit may arrive on the clk_en cycle immediately after `frame_done`. It is accepted normally.

## Test plan
- WORD_W=8, port_sel=2, 16 bits 0xA5,0x3C with `clk_en` every 4th clk, `frame_done` on bit 16:
  - `data_out[23:16]=0xA5` with `word_valid=4'b0100`, then `data_out[23:16]=0x3C` with a second pulse;
  - `frame_words=2`, `frame_err=0`;
  - other slices remain 0.
- 11 bits to port 1 (0xFF then 3 bits) -> `data_out[15:8]=0xFF`, `frame_end` with `frame_words=1`, `frame_err=1`; the partial bits never appear.
- `port_sel` switched 0 -> 3 after the first bit -> word still lands in port 0; port 3 slice unchanged.
- `ser_valid` dropped for 5 clk_en cycles mid-word, then resumed -> word identical to the gap-free case; no spurious pulses.
- `rst` pulsed after 5 bits, then a fresh 8-bit 0x81 frame to port 0 -> `data_out[7:0]=0x81`, `frame_words=1`, `frame_err=0`.
- 300 words in one frame -> `frame_words=255` (saturated); `word_valid` pulses 300 times.
